// File: rtl/enc_speed_sched.sv
// Quadrature decoder supervisor: sequences decoder reset on mode change and
// produces periodic speed/position samples over a valid/ready handshake.
module enc_speed_sched #(
  parameter logic [2:0] DEFAULT_MODE = 3'd4,
  parameter int         CLR_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [2:0]  cfg_mode,
  output logic        cfg_ack,
  output logic        cfg_err,
  input  logic [15:0] period,
  output logic [2:0]  enc_mode,
  output logic        enc_rst,
  input  logic [15:0] enc_count,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic [15:0] smp_speed,
  output logic [15:0] smp_pos,
  output logic        overrun
);

  typedef enum logic [1:0] {CLEAR, SETTLE, RUN} state_t;

  localparam logic [3:0]  CLR_LAST = 4'(CLR_CYCLES - 1);
  localparam logic [15:0] POS_REST = 16'h8000;

  state_t      state_reg, state_next;
  logic [2:0]  mode_reg, mode_next;
  logic [3:0]  clr_cnt_reg, clr_cnt_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] last_pos_reg, last_pos_next;
  logic        smp_valid_reg, smp_valid_next;
  logic [15:0] speed_reg, speed_next;
  logic [15:0] pos_reg, pos_next;
  logic        overrun_reg, overrun_next;
  logic        ack_reg, ack_next;
  logic        err_reg, err_next;
  logic        due;
  logic        mode_ok;

  assign mode_ok = (cfg_mode == 3'd1) || (cfg_mode == 3'd2) || (cfg_mode == 3'd4);

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    clr_cnt_next   = clr_cnt_reg;
    cnt_next       = cnt_reg;
    last_pos_next  = last_pos_reg;
    smp_valid_next = smp_valid_reg;
    speed_next     = speed_reg;
    pos_next       = pos_reg;
    overrun_next   = overrun_reg;
    ack_next       = 1'b0;
    err_next       = 1'b0;
    due            = 1'b0;

    if (smp_valid_reg && smp_ready)
      smp_valid_next = 1'b0;

    case (state_reg)
      CLEAR: begin
        if (clr_cnt_reg == CLR_LAST) begin
          state_next   = SETTLE;
          clr_cnt_next = 4'd0;
        end else begin
          clr_cnt_next = clr_cnt_reg + 4'd1;
        end
      end
      SETTLE: begin
        state_next    = RUN;
        last_pos_next = POS_REST;
        cnt_next      = 16'd0;
      end
      RUN: begin
        // >= rather than == so a period shrunk mid-interval still fires promptly
        if (period == 16'd0) begin
          cnt_next = 16'd0;
        end else if (cnt_reg >= period - 16'd1) begin
          due      = 1'b1;
          cnt_next = 16'd0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end

        if (cfg_req) begin
          if (mode_ok) begin
            ack_next       = 1'b1;
            mode_next      = cfg_mode;
            smp_valid_next = 1'b0;
            overrun_next   = 1'b0;
            state_next     = CLEAR;
            clr_cnt_next   = 4'd0;
          end else begin
            err_next = 1'b1;
          end
        end else if (due) begin
          last_pos_next = enc_count;
          if (!smp_valid_reg || smp_ready) begin
            smp_valid_next = 1'b1;
            speed_next     = enc_count - last_pos_reg;
            pos_next       = enc_count;
          end else begin
            overrun_next = 1'b1;
          end
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CLEAR;
      mode_reg      <= DEFAULT_MODE;
      clr_cnt_reg   <= 4'd0;
      cnt_reg       <= 16'd0;
      last_pos_reg  <= POS_REST;
      smp_valid_reg <= 1'b0;
      speed_reg     <= 16'd0;
      pos_reg       <= POS_REST;
      overrun_reg   <= 1'b0;
      ack_reg       <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      clr_cnt_reg   <= clr_cnt_next;
      cnt_reg       <= cnt_next;
      last_pos_reg  <= last_pos_next;
      smp_valid_reg <= smp_valid_next;
      speed_reg     <= speed_next;
      pos_reg       <= pos_next;
      overrun_reg   <= overrun_next;
      ack_reg       <= ack_next;
      err_reg       <= err_next;
    end
  end

  assign enc_rst   = (state_reg == CLEAR);
  assign enc_mode  = mode_reg;
  assign cfg_ack   = ack_reg;
  assign cfg_err   = err_reg;
  assign smp_valid = smp_valid_reg;
  assign smp_speed = speed_reg;
  assign smp_pos   = pos_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_enc_speed_sched.sv
// Directed bench for enc_speed_sched: inputs driven and outputs checked on
// the falling edge, expected values hand-computed.
module tb_enc_speed_sched;
    logic        clk;
    logic        rst;
    logic        cfg_req;
    logic [2:0]  cfg_mode;
    logic        cfg_ack;
    logic        cfg_err;
    logic [15:0] period;
    logic [2:0]  enc_mode;
    logic        enc_rst;
    logic [15:0] enc_count;
    logic        smp_valid;
    logic        smp_ready;
    logic [15:0] smp_speed;
    logic [15:0] smp_pos;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    enc_speed_sched dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_req   (cfg_req),
        .cfg_mode  (cfg_mode),
        .cfg_ack   (cfg_ack),
        .cfg_err   (cfg_err),
        .period    (period),
        .enc_mode  (enc_mode),
        .enc_rst   (enc_rst),
        .enc_count (enc_count),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_speed (smp_speed),
        .smp_pos   (smp_pos),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        #100000;
        bad++;
        $error("FAIL timeout: test did not complete, total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst       = 1'b1;
        cfg_req   = 1'b0;
        cfg_mode  = 3'd0;
        period    = 16'd10;
        enc_count = 16'h8000;
        smp_ready = 1'b1;
        step(3);

        // reset state
        check("rst_valid",   smp_valid, 1'b0);
        check("rst_speed",   smp_speed, 16'h0000);
        check("rst_pos",     smp_pos,   16'h8000);
        check("rst_overrun", overrun,   1'b0);
        check("rst_ack",     cfg_ack,   1'b0);
        check("rst_err",     cfg_err,   1'b0);
        check("rst_encrst",  enc_rst,   1'b1);
        check("rst_mode",    enc_mode,  3'd4);
        $display("reset state checked");

        // release: two CLEAR cycles, SETTLE, then RUN
        rst = 1'b0;
        check("clr0_encrst", enc_rst, 1'b1);
        step(1);
        check("clr1_encrst", enc_rst, 1'b1);
        check("clr1_mode",   enc_mode, 3'd4);
        step(1);
        check("settle_encrst", enc_rst, 1'b0);
        step(1);
        check("run_encrst", enc_rst, 1'b0);
        check("run_valid",  smp_valid, 1'b0);
        for (int i = 1; i < 10; i++) begin
            step(1);
            check("pre_first_valid", smp_valid, 1'b0);
        end
        step(1);
        check("first_valid", smp_valid, 1'b1);
        check("first_speed", smp_speed, 16'h0000);
        check("first_pos",   smp_pos,   16'h8000);
        $display("reset release: first sample speed=%h pos=%h", smp_speed, smp_pos);

        // ramp +3 per interval
        enc_count = 16'h8003;
        step(1);
        check("xfer_clear", smp_valid, 1'b0);
        step(9);
        check("ramp1_valid", smp_valid, 1'b1);
        check("ramp1_speed", smp_speed, 16'h0003);
        check("ramp1_pos",   smp_pos,   16'h8003);
        $display("ramp sample speed=%h pos=%h", smp_speed, smp_pos);
        enc_count = 16'h8006;
        step(10);
        check("ramp2_speed", smp_speed, 16'h0003);
        check("ramp2_pos",   smp_pos,   16'h8006);
        $display("ramp sample speed=%h pos=%h", smp_speed, smp_pos);

        // wrap-around deltas
        enc_count = 16'hFFFE;
        step(10);
        check("wrapa_pos", smp_pos, 16'hFFFE);
        enc_count = 16'h0002;
        step(10);
        check("wrapb_speed", smp_speed, 16'h0004);
        check("wrapb_pos",   smp_pos,   16'h0002);
        $display("wrap sample speed=%h pos=%h", smp_speed, smp_pos);
        enc_count = 16'h8000;
        step(10);
        check("neg_pre_pos", smp_pos, 16'h8000);
        enc_count = 16'h7FF6;
        step(10);
        check("neg_speed", smp_speed, 16'hFFF6);
        check("neg_pos",   smp_pos,   16'h7FF6);
        $display("negative sample speed=%h pos=%h", smp_speed, smp_pos);

        // backpressure across three intervals
        smp_ready = 1'b0;
        enc_count = 16'h7FF9;
        for (int k = 0; k < 3; k++) begin
            step(10);
            check("bp_valid",   smp_valid, 1'b1);
            check("bp_speed",   smp_speed, 16'hFFF6);
            check("bp_pos",     smp_pos,   16'h7FF6);
            check("bp_overrun", overrun,   1'b1);
            $display("backpressure interval %0d speed=%h overrun=%b", k, smp_speed, overrun);
        end
        smp_ready = 1'b1;
        step(1);
        check("bp_xfer_valid",   smp_valid, 1'b0);
        check("bp_xfer_overrun", overrun,   1'b1);
        enc_count = 16'h7FFC;
        step(9);
        check("post_bp_valid", smp_valid, 1'b1);
        check("post_bp_speed", smp_speed, 16'h0003);
        check("post_bp_pos",   smp_pos,   16'h7FFC);
        $display("post-backpressure sample speed=%h pos=%h", smp_speed, smp_pos);

        // accepted reconfiguration to mode 2
        cfg_req  = 1'b1;
        cfg_mode = 3'd2;
        step(1);
        cfg_req = 1'b0;
        check("cfg2_ack",     cfg_ack,   1'b1);
        check("cfg2_err",     cfg_err,   1'b0);
        check("cfg2_mode",    enc_mode,  3'd2);
        check("cfg2_encrst",  enc_rst,   1'b1);
        check("cfg2_overrun", overrun,   1'b0);
        check("cfg2_valid",   smp_valid, 1'b0);
        step(1);
        check("cfg2_ack_pulse", cfg_ack, 1'b0);
        check("cfg2_clr1",      enc_rst, 1'b1);
        step(1);
        check("cfg2_settle", enc_rst, 1'b0);
        step(1);
        $display("reconfig mode=%0d", enc_mode);

        // rejected mode 3 in RUN
        cfg_req  = 1'b1;
        cfg_mode = 3'd3;
        step(1);
        cfg_req = 1'b0;
        check("cfg3_err",    cfg_err,  1'b1);
        check("cfg3_ack",    cfg_ack,  1'b0);
        check("cfg3_mode",   enc_mode, 3'd2);
        check("cfg3_encrst", enc_rst,  1'b0);
        step(1);
        check("cfg3_err_pulse", cfg_err, 1'b0);
        $display("reject mode 3 err seen");

        // reconfiguration in the cycle a sample is due
        enc_count = 16'h8010;
        step(7);
        cfg_req  = 1'b1;
        cfg_mode = 3'd1;
        step(1);
        check("coll_valid",  smp_valid, 1'b0);
        check("coll_ack",    cfg_ack,   1'b1);
        check("coll_mode",   enc_mode,  3'd1);
        check("coll_encrst", enc_rst,   1'b1);
        // request while in CLEAR is ignored
        cfg_mode = 3'd2;
        step(1);
        cfg_req = 1'b0;
        check("clrreq_ack",  cfg_ack,  1'b0);
        check("clrreq_err",  cfg_err,  1'b0);
        check("clrreq_mode", enc_mode, 3'd1);
        $display("collision and CLEAR-time request checked");

        // reset mid-CLEAR restarts the sequence with default mode
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rrst_mode",   enc_mode, 3'd4);
        check("rrst_encrst", enc_rst,  1'b1);
        step(1);
        check("rrst_clr1", enc_rst, 1'b1);
        step(1);
        check("rrst_settle", enc_rst, 1'b0);
        step(1);
        $display("reset mid-CLEAR restart mode=%0d", enc_mode);

        // period 0 produces nothing
        period = 16'd0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            check("p0_valid", smp_valid, 1'b0);
        end
        $display("period 0 idle checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
